wb_port_arbiter: RTL and testbench

Arbiter and sequencer for the single register-file write port at the write-back end of the 8-bit pipeline. Two requesters compete for the port: the data-memory load path (DM) and the ALU result path (ALU). Each cycle the block grants at most one write and registers the selected address and data toward the register file. Fixed priority favours DM, same-register collisions are squashed in program order, and a starvation counter bounds ALU wait time.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_arb_starve_ctr.sv | 50 +++++
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back port arbiter.
// Holds default bus widths, the arbiter state encoding and the r0 address.
package wb_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  // r0 is hardwired to zero; writes to it complete but never reach the file
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    NORMAL    = 1'b0,
    ALU_BOOST = 1'b1
  } arb_state_e;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_starve_ctr.sv
// Saturating count of cycles the ALU requester has been denied.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   alu_valid    ALU request pending
//   alu_ready    ALU request granted this cycle
//   in_boost     arbiter currently in ALU_BOOST
//   limit_hit    counter has reached STARVE_LIMIT
//   clear        counter clears at the next edge (ALU handshake or boost abandoned)
module wb_arb_starve_ctr
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic alu_ready,
  input  logic in_boost,
  output logic limit_hit,
  output logic clear
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A boost with the ALU request withdrawn is abandoned, so the count restarts
  assign clear     = (alu_valid && alu_ready) || (in_boost && !alu_valid);
  assign limit_hit = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Next count: clear wins, otherwise count denied cycles up to the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (alu_valid && !alu_ready && !limit_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : wb_arb_starve_ctr

// File: rtl/wb_port_arbiter.sv
// Arbiter for the single register-file write port at write-back.
// DM has fixed priority unless the ALU has starved long enough to earn a boost;
// same-register collisions keep only the younger ALU write.
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   dm_valid/addr/data, dm_ready  load-path write request and combinational accept
//   alu_valid/addr/data, alu_ready ALU write request and combinational accept
//   rf_we/rf_waddr/rf_wdata      registered register-file write
//   boost                        arbiter is in ALU_BOOST
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dm_valid,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic              dm_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              boost
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              rf_we_q;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [ADDR_W-1:0] rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] rf_wdata_d;

  logic              dm_rdy;
  logic              alu_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_go;
  logic              limit_hit;
  logic              ctr_clear;

  wb_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_rdy),
    .in_boost  (state_q == ALU_BOOST),
    .limit_hit (limit_hit),
    .clear     (ctr_clear)
  );

  // Grant: collisions accept both sides, otherwise the current priority side wins
  always_comb begin
    dm_rdy  = 1'b0;
    alu_rdy = 1'b0;
    if (!reset) begin
      if (dm_valid && alu_valid) begin
        if (dm_addr == alu_addr) begin
          dm_rdy  = 1'b1;
          alu_rdy = 1'b1;
        end else if (state_q == ALU_BOOST) begin
          alu_rdy = 1'b1;
        end else begin
          dm_rdy = 1'b1;
        end
      end else begin
        dm_rdy  = dm_valid;
        alu_rdy = alu_valid;
      end
    end
  end

  // ALU side is selected whenever it is accepted; on a collision DM is squashed
  assign wr_addr = alu_rdy ? alu_addr : dm_addr;
  assign wr_data = alu_rdy ? alu_data : dm_data;
  assign wr_go   = (dm_rdy || alu_rdy) && (wr_addr != ADDR_W'(REG_ZERO));

  // Next state and write-port registers
  always_comb begin
    state_d    = state_q;
    rf_we_d    = wr_go;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_go) begin
      rf_waddr_d = wr_addr;
      rf_wdata_d = wr_data;
    end
    case (state_q)
      NORMAL: begin
        if (limit_hit && alu_valid && !alu_rdy) begin
          state_d = ALU_BOOST;
        end
      end
      ALU_BOOST: begin
        if (ctr_clear) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= NORMAL;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign dm_ready  = dm_rdy;
  assign alu_ready = alu_rdy;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign boost     = (state_q == ALU_BOOST);

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes expected register-file
// writes into a queue; a monitor pops one per rf_we pulse and compares.
module tb_wb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       dm_valid;
  logic [2:0] dm_addr;
  logic [7:0] dm_data;
  logic       dm_ready;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       boost;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];

  wb_port_arbiter #(
    .DATA_W(8),
    .ADDR_W(3),
    .STARVE_LIMIT(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dm_valid  (dm_valid),
    .dm_addr   (dm_addr),
    .dm_data   (dm_data),
    .dm_ready  (dm_ready),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .boost     (boost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic drive(input logic dv, input logic [2:0] da, input logic [7:0] dd,
                       input logic av, input logic [2:0] aa, input logic [7:0] ad);
    dm_valid  = dv;
    dm_addr   = da;
    dm_data   = dd;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    end
  endtask

  // Four cycles of DM traffic to fresh addresses while the ALU waits; each is a DM grant
  task automatic starve_run(input logic [2:0] aa, input logic [7:0] ad,
                            input logic [3:0][2:0] das, input logic [7:0] dbase);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, das[i], dbase + 8'(i), 1'b1, aa, ad);
      #1;
      chk("starve_boost_low", 32'(boost), 32'd0);
      chk("starve_dm_ready", 32'(dm_ready), 32'd1);
      chk("starve_alu_ready", 32'(alu_ready), 32'd0);
      push_exp(das[i], dbase + 8'(i));
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_write actual=r%0d=0x%0h expected=no write", rf_waddr, rf_wdata);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(rf_waddr), 32'(w.a));
          chk("wr_data", 32'(rf_wdata), 32'(w.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_boost", 32'(boost), 32'd0);
    chk("rst_dm_ready", 32'(dm_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    idle(2);
    @(negedge clk);
    reset = 1'b0;

    // DM-only write r5 = 0x3C
    @(negedge clk);
    drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 8'h00);
    #1;
    chk("dm_only_ready", 32'(dm_ready), 32'd1);
    chk("dm_only_alu_ready", 32'(alu_ready), 32'd0);
    push_exp(3'd5, 8'h3C);
    idle(2);

    // Starvation: ALU r4=0x22 waits 4 cycles, boost, then ALU wins
    starve_run(3'd4, 8'h22, {3'd6, 3'd5, 3'd3, 3'd2}, 8'h11);
    @(negedge clk);
    drive(1'b1, 3'd7, 8'h15, 1'b1, 3'd4, 8'h22);
    #1;
    chk("boost_high", 32'(boost), 32'd1);
    chk("boost_alu_ready", 32'(alu_ready), 32'd1);
    chk("boost_dm_ready", 32'(dm_ready), 32'd0);
    push_exp(3'd4, 8'h22);
    @(negedge clk);
    drive(1'b1, 3'd7, 8'h15, 1'b0, 3'd0, 8'h00);
    #1;
    chk("boost_cleared", 32'(boost), 32'd0);
    chk("post_boost_dm_ready", 32'(dm_ready), 32'd1);
    push_exp(3'd7, 8'h15);
    idle(2);

    // Collision on r6: ALU data wins, single write
    @(negedge clk);
    drive(1'b1, 3'd6, 8'hAA, 1'b1, 3'd6, 8'h55);
    #1;
    chk("coll_dm_ready", 32'(dm_ready), 32'd1);
    chk("coll_alu_ready", 32'(alu_ready), 32'd1);
    push_exp(3'd6, 8'h55);
    idle(2);

    // ALU write to r0: accepted, no write, outputs hold r6=0x55
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF);
    #1;
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    #1;
    chk("r0_rf_we", 32'(rf_we), 32'd0);
    chk("r0_waddr_hold", 32'(rf_waddr), 32'd6);
    chk("r0_wdata_hold", 32'(rf_wdata), 32'h55);
    idle(1);

    // Reset while in ALU_BOOST with both requests pending
    starve_run(3'd4, 8'h33, {3'd5, 3'd3, 3'd2, 3'd1}, 8'h80);
    @(negedge clk);
    chk("pre_rst_boost", 32'(boost), 32'd1);
    drive(1'b1, 3'd6, 8'h20, 1'b1, 3'd4, 8'h33);
    reset = 1'b1;
    #1;
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_boost", 32'(boost), 32'd0);
    chk("midrst_dm_ready", 32'(dm_ready), 32'd0);
    chk("midrst_alu_ready", 32'(alu_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst_dm_ready", 32'(dm_ready), 32'd1);
    chk("postrst_alu_ready", 32'(alu_ready), 32'd0);
    push_exp(3'd6, 8'h20);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h33);
    #1;
    chk("postrst_alu_grant", 32'(alu_ready), 32'd1);
    push_exp(3'd4, 8'h33);
    idle(2);

    // ALU withdraws during ALU_BOOST: DM granted, FSM and counter restart
    starve_run(3'd7, 8'h44, {3'd5, 3'd3, 3'd2, 3'd1}, 8'hC0);
    @(negedge clk);
    chk("drop_boost_high", 32'(boost), 32'd1);
    drive(1'b1, 3'd6, 8'h50, 1'b0, 3'd0, 8'h00);
    #1;
    chk("drop_dm_ready", 32'(dm_ready), 32'd1);
    chk("drop_alu_ready", 32'(alu_ready), 32'd0);
    push_exp(3'd6, 8'h50);
    // Full four-cycle wait again proves the counter restarted from zero
    starve_run(3'd7, 8'h44, {3'd5, 3'd3, 3'd2, 3'd1}, 8'hD0);
    @(negedge clk);
    drive(1'b1, 3'd6, 8'h60, 1'b1, 3'd7, 8'h44);
    #1;
    chk("reboost_high", 32'(boost), 32'd1);
    chk("reboost_alu_ready", 32'(alu_ready), 32'd1);
    push_exp(3'd7, 8'h44);
    @(negedge clk);
    drive(1'b1, 3'd6, 8'h60, 1'b0, 3'd0, 8'h00);
    #1;
    chk("reboost_exit", 32'(boost), 32'd0);
    push_exp(3'd6, 8'h60);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_port_arbiter
